// File: rtl/bcd_timebase_counter.sv
// ---------------------------------------------------------------------------
// bcd_timebase_counter
//   Prescaled time base driving a chain of cascaded BCD digits, for stopwatch
//   and 7-segment display paths. A two-state start/stop FSM gates counting,
//   clear zeroes the count without changing the run state.
//
// Optional feature (macro BCD_LAP_EN):
//   When defined, a rising edge on lap toggles a display freeze (lap hold).
//   When undefined, lap is ignored and no hold register exists.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   start      in   level; STOPPED -> RUNNING
//   stop       in   level; RUNNING -> STOPPED (wins over start)
//   clear      in   synchronous zero of prescaler, digits and lap hold
//   lap        in   lap-hold toggle (BCD_LAP_EN only)
//   digits_out out  displayed BCD value, digit 0 in [3:0]
//   tick       out  one-cycle pulse per counted tick
//   carry_out  out  one-cycle pulse when the whole chain wraps to zero
//   running    out  high while in RUNNING
// ---------------------------------------------------------------------------
module bcd_timebase_counter #(
    parameter int CLK_DIV = 2_500_000,
    parameter int DIV_W   = 23,
    parameter int DIGITS  = 4,
    parameter int TOP_MOD = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  lap,
    output logic [4*DIGITS-1:0]   digits_out,
    output logic                  tick,
    output logic                  carry_out,
    output logic                  running
);

    localparam logic [DIV_W-1:0] TERM    = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       TOP_MAX = 4'(TOP_MOD - 1);

    typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} state_t;

    state_t                  r_state;
    logic                    r_running;
    logic [DIV_W-1:0]        r_presc;
    logic [DIGITS-1:0][3:0]  r_digits;
    logic [DIGITS-1:0][3:0]  r_dout;
    logic                    r_tick;
    logic                    r_carry;

    logic                    w_tick_en;
    logic                    w_chain;
    logic                    w_carry;
    logic [DIGITS-1:0][3:0]  w_dig_nxt;
    logic [DIGITS-1:0][3:0]  w_out_nxt;

    assign digits_out = r_dout;
    assign tick       = r_tick;
    assign carry_out  = r_carry;
    assign running    = r_running;

    // clear suppresses the tick on its edge
    assign w_tick_en = (r_state == ST_RUNNING) && (r_presc == TERM) && !clear;

    // All digits resolve in one cycle: w_chain is "tick and every lower
    // digit at its max", so it doubles as the chain carry after the loop.
    always_comb begin
        w_chain   = w_tick_en;
        w_dig_nxt = r_digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_chain) begin
                if (r_digits[i] == ((i == DIGITS - 1) ? TOP_MAX : 4'd9))
                    w_dig_nxt[i] = 4'd0;
                else
                    w_dig_nxt[i] = r_digits[i] + 4'd1;
            end
            w_chain = w_chain && (r_digits[i] == ((i == DIGITS - 1) ? TOP_MAX : 4'd9));
        end
        w_carry = w_chain;
        if (clear)
            w_dig_nxt = '0;
    end

`ifdef BCD_LAP_EN
    logic                    r_lap_q;
    logic                    r_lap_q2;
    logic                    r_lap_hold;
    logic [DIGITS-1:0][3:0]  r_hold;
    logic                    w_lap_rise;
    logic                    w_hold_nxt;
    logic [DIGITS-1:0][3:0]  w_hold_val_nxt;

    assign w_lap_rise = r_lap_q && !r_lap_q2;

    always_comb begin
        w_hold_nxt     = r_lap_hold;
        w_hold_val_nxt = r_hold;
        if (clear) begin
            w_hold_nxt = 1'b0;
        end else if (w_lap_rise) begin
            w_hold_nxt = !r_lap_hold;
            // entering hold snapshots the live count
            if (!r_lap_hold)
                w_hold_val_nxt = r_digits;
        end
        w_out_nxt = w_hold_nxt ? w_hold_val_nxt : w_dig_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lap_q    <= 1'b0;
            r_lap_q2   <= 1'b0;
            r_lap_hold <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_lap_q    <= lap;
            r_lap_q2   <= r_lap_q;
            r_lap_hold <= w_hold_nxt;
            r_hold     <= w_hold_val_nxt;
        end
    end
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign w_out_nxt    = w_dig_nxt;
`endif

    // Run-control FSM; running is registered alongside the state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_STOPPED;
            r_running <= 1'b0;
        end else begin
            case (r_state)
                ST_STOPPED: if (start && !stop) begin
                    r_state   <= ST_RUNNING;
                    r_running <= 1'b1;
                end
                ST_RUNNING: if (stop) begin
                    r_state   <= ST_STOPPED;
                    r_running <= 1'b0;
                end
                default: begin
                    r_state   <= ST_STOPPED;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    // Prescaler holds while stopped so a resume keeps the same phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_digits <= '0;
            r_dout   <= '0;
            r_tick   <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            if (clear)
                r_presc <= '0;
            else if (r_state == ST_RUNNING)
                r_presc <= (r_presc == TERM) ? '0 : r_presc + DIV_W'(1);
            r_digits <= w_dig_nxt;
            r_dout   <= w_out_nxt;
            r_tick   <= w_tick_en;
            r_carry  <= w_carry;
        end
    end

endmodule
